// File: rtl/mux_sel_sequencer.sv
//==============================================================================
// Module      : mux_sel_sequencer
// Description : Control stage for an 8:1 bit-select mux. Accepts an 8-bit
//               word over valid/ready, holds it on the mux data inputs and
//               steps the mux select through all eight positions. Each
//               selected bit is returned as a serial beat with backpressure.
//               Optional macro MUX_SEQ_PARITY_EN appends a ninth beat that
//               carries the even parity of the word.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux_sel_sequencer #(
    parameter int MSB_FIRST = 0,
    parameter int IDLE_GAP  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    output logic [7:0] mux_in,
    output logic [2:0] mux_sel,
    input  logic       mux_out,
    output logic       ser_valid,
    output logic       ser_data,
    output logic       ser_last,
    input  logic       ser_ready,
    output logic       busy
);

`ifdef MUX_SEQ_PARITY_EN
    localparam int CNT_W = 4;
    // Beat index 8 is the parity beat.
    localparam logic [CNT_W-1:0] C_FINAL = CNT_W'(8);
`else
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] C_FINAL = CNT_W'(7);
`endif

    // Last beat index that is a real data bit (select still advancing below it).
    localparam logic [CNT_W-1:0] C_LAST_BIT  = CNT_W'(7);
    localparam logic [2:0]       C_SEL_FIRST = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
    localparam bit               C_HAS_GAP   = (IDLE_GAP > 0);
    localparam logic [3:0]       C_GAP_LOAD  = C_HAS_GAP ? 4'(IDLE_GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_mux_in;
    logic [2:0]       r_mux_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gap;

    // Sequencer: word capture, select stepping, gap countdown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mux_in  <= 8'h00;
            r_mux_sel <= 3'd0;
            r_cnt     <= '0;
            r_gap     <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // load_ready is high whenever IDLE and out of reset.
                    if (load_valid) begin
                        r_mux_in  <= load_data;
                        r_mux_sel <= C_SEL_FIRST;
                        r_cnt     <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        if (r_cnt == C_FINAL) begin
                            r_gap   <= C_GAP_LOAD;
                            r_state <= C_HAS_GAP ? ST_GAP : ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            // Select stops at the final index; a parity beat keeps it there.
                            if (r_cnt < C_LAST_BIT) begin
                                r_mux_sel <= (MSB_FIRST != 0) ? r_mux_sel - 3'd1
                                                              : r_mux_sel + 3'd1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MUX_SEQ_PARITY_EN
    logic r_par;

    // Parity of the accepted word, served on the ninth beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (r_state == ST_IDLE && load_valid) begin
            r_par <= ^load_data;
        end
    end

    assign ser_data = r_cnt[3] ? r_par : mux_out;
`else
    assign ser_data = mux_out;
`endif

    assign load_ready = rst_n && (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign ser_valid  = (r_state == ST_SHIFT);
    assign ser_last   = (r_state == ST_SHIFT) && (r_cnt == C_FINAL);
    assign mux_in     = r_mux_in;
    assign mux_sel    = r_mux_sel;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
//==============================================================================
// Module      : tb_mux_sel_sequencer
// Description : Bench for mux_sel_sequencer. Two instances (LSB-first with no
//               gap, MSB-first with a 3-cycle gap) share one stimulus stream
//               and are each compared against a beat-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mux_sel_sequencer;

`ifdef MUX_SEQ_PARITY_EN
    localparam int LAST_BEAT = 8;
`else
    localparam int LAST_BEAT = 7;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_SHIFT = 1;
    localparam int PH_GAP   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       ser_ready;

    logic       w_load_ready [2];
    logic [7:0] w_mux_in     [2];
    logic [2:0] w_mux_sel    [2];
    logic       w_mux_out    [2];
    logic       w_ser_valid  [2];
    logic       w_ser_data   [2];
    logic       w_ser_last   [2];
    logic       w_busy       [2];

    int tests = 0;
    int fails = 0;

    // Reference model state per instance.
    int         m_ph   [2];
    int         m_beat [2];
    int         m_gap  [2];
    logic [7:0] m_word [2];
    logic [2:0] m_sel  [2];

    always #5 clk = ~clk;

    // Behavioural 8:1 muxes closing the loop for each instance.
    assign w_mux_out[0] = w_mux_in[0][w_mux_sel[0]];
    assign w_mux_out[1] = w_mux_in[1][w_mux_sel[1]];

    mux_sel_sequencer #(.MSB_FIRST(0), .IDLE_GAP(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(w_load_ready[0]),
        .load_data (load_data),
        .mux_in    (w_mux_in[0]),
        .mux_sel   (w_mux_sel[0]),
        .mux_out   (w_mux_out[0]),
        .ser_valid (w_ser_valid[0]),
        .ser_data  (w_ser_data[0]),
        .ser_last  (w_ser_last[0]),
        .ser_ready (ser_ready),
        .busy      (w_busy[0])
    );

    mux_sel_sequencer #(.MSB_FIRST(1), .IDLE_GAP(3)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(w_load_ready[1]),
        .load_data (load_data),
        .mux_in    (w_mux_in[1]),
        .mux_sel   (w_mux_sel[1]),
        .mux_out   (w_mux_out[1]),
        .ser_valid (w_ser_valid[1]),
        .ser_data  (w_ser_data[1]),
        .ser_last  (w_ser_last[1]),
        .ser_ready (ser_ready),
        .busy      (w_busy[1])
    );

    function automatic bit is_msb(input int i);
        return (i == 1);
    endfunction

    function automatic int gap_len(input int i);
        return (i == 1) ? 3 : 0;
    endfunction

    // Select position for a beat: data beats walk the word, parity beat stays at the end.
    function automatic logic [2:0] sel_of(input int i, input int beat);
        int b;
        b = (beat > 7) ? 7 : beat;
        return is_msb(i) ? 3'(7 - b) : 3'(b);
    endfunction

    task automatic chk(input string tag, input int i, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    // Compare every instance against its model for the current cycle.
    task automatic check_all();
        logic [2:0] esel;
        logic       eval;
        logic       edata;
        for (int i = 0; i < 2; i++) begin
            eval = (m_ph[i] == PH_SHIFT);
            esel = eval ? sel_of(i, m_beat[i]) : m_sel[i];
            chk("load_ready", i, 8'(w_load_ready[i]), 8'(rst_n && m_ph[i] == PH_IDLE));
            chk("busy",       i, 8'(w_busy[i]),       8'(m_ph[i] != PH_IDLE));
            chk("ser_valid",  i, 8'(w_ser_valid[i]),  8'(eval));
            chk("ser_last",   i, 8'(w_ser_last[i]),   8'(eval && m_beat[i] == LAST_BEAT));
            chk("mux_sel",    i, 8'(w_mux_sel[i]),    8'(esel));
            chk("mux_in",     i, w_mux_in[i],         m_word[i]);
            if (eval) begin
                edata = (m_beat[i] > 7) ? ^m_word[i] : m_word[i][esel];
                chk("ser_data", i, 8'(w_ser_data[i]), 8'(edata));
            end
        end
    endtask

    // Advance each model by one clock using the inputs applied this cycle.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_ph[i]   = PH_IDLE;
                m_word[i] = 8'h00;
                m_beat[i] = 0;
                m_gap[i]  = 0;
                m_sel[i]  = 3'd0;
            end else begin
                case (m_ph[i])
                    PH_IDLE: if (load_valid) begin
                        m_word[i] = load_data;
                        m_beat[i] = 0;
                        m_ph[i]   = PH_SHIFT;
                    end
                    PH_SHIFT: if (ser_ready) begin
                        if (m_beat[i] == LAST_BEAT) begin
                            m_gap[i] = gap_len(i);
                            m_ph[i]  = (m_gap[i] > 0) ? PH_GAP : PH_IDLE;
                        end else begin
                            m_beat[i]++;
                        end
                    end
                    default: begin
                        m_gap[i]--;
                        if (m_gap[i] == 0) m_ph[i] = PH_IDLE;
                    end
                endcase
                if (m_ph[i] == PH_SHIFT) m_sel[i] = sel_of(i, m_beat[i]);
            end
        end
    endtask

    task automatic step(input logic rn, input logic lv, input logic [7:0] ld, input logic sr);
        @(negedge clk);
        rst_n      = rn;
        load_valid = lv;
        load_data  = ld;
        ser_ready  = sr;
        #1;
        check_all();
        @(posedge clk);
        model_update();
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        ser_ready  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = PH_IDLE; m_beat[i] = 0; m_gap[i] = 0;
            m_word[i] = 8'h00; m_sel[i] = 3'd0;
        end
        @(posedge clk);

        // Reset held low for two cycles, then idle.
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Word 8'hA5 with no backpressure.
        step(1'b1, 1'b1, 8'hA5, 1'b1);
        for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Word 8'h3C with stalls on beats 3 and 6.
        step(1'b1, 1'b1, 8'h3C, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Back-to-back words with load_valid held high.
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        for (int k = 0; k < 24; k++) step(1'b1, 1'b1, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Reset in the middle of word 8'h96, then 8'h01.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h96, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h01, 1'b1);
        for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Randomised traffic with backpressure and rare resets.
        for (int k = 0; k < 3000; k++) begin
            step(1'($urandom_range(0, 149) != 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 1'($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
Upstream sequencer for the 8:1 bit-select mux. It accepts an 8-bit word over a valid/ready handshake, holds the word on the mux data inputs and steps the mux select through all eight positions. It returns each selected bit as a serial stream with downstream backpressure. It is the control stage that turns the combinational 8:1 mux into a parallel-to-serial converter.

Parameters:
MSB_FIRST, 0, 0 = select order 0→7 (LSB first); 1 = order 7→0.
IDLE_GAP, 0, number of idle cycles (0..15) inserted after the last beat of a word before load_ready reasserts.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
load_valid  input  1  upstream word available.
load_ready  output  1  sequencer can accept a word; high only in IDLE and while rst_n=1.
load_data  input  8  word to serialise.
mux_in  output  8  registered word, wired to the mux data inputs.
mux_sel  output  3  registered select, wired to the mux select.
mux_out  input  1  mux output, returned combinationally.
ser_valid  output  1  serial beat valid.
ser_data  output  1  serial bit.
ser_last  output  1  final beat of the current word.
ser_ready  input  1  downstream accepts the beat.
busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - mux_in=8'h00, mux_sel=3'd0, bit counter=0, gap counter=0.
  - ser_valid=0, ser_last=0, busy=0.
  - load_ready is forced to 0 while rst_n=0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - load_ready=1.
  - On load_valid & load_ready:
    - mux_in<=load_data.
    - mux_sel<= 0 when MSB_FIRST=0, 7 when MSB_FIRST=1.
    - Bit counter<=0; next state SHIFT.
  - Otherwise hold mux_in and mux_sel.
- SHIFT:
  - ser_valid=1 (decoded from the state register, no combinational path from inputs).
  - ser_data=mux_out (combinational pass-through).
  - ser_last=1 when bit counter=7.
- Beat transfer = ser_valid & ser_ready.
  - On transfer with counter<7: counter+1; mux_sel +1 (MSB_FIRST=0) or −1 (MSB_FIRST=1).
  - On transfer with counter=7: next state is GAP if IDLE_GAP>0 (gap counter loaded with IDLE_GAP−1), else IDLE. mux_sel holds its value.
- Stall: while ser_ready=0 in SHIFT, mux_in, mux_sel, counter, ser_data and ser_last hold stable. ser_valid must not drop once asserted until the beat transfers.
- GAP: busy=1, load_ready=0, ser_valid=0. The gap counter decrements each cycle; at 0 the next state is IDLE.
- Latency: the first beat is valid the cycle after load acceptance. A word takes a minimum of 8 cycles in SHIFT. With IDLE_GAP=0, load_ready reasserts the cycle after the last transfer, giving one bubble between words. A new word cannot be accepted in the same cycle as the last beat.
- Counter and select wrap: counters are 3 bits wide and never wrap inside a word. Stepping of mux_sel stops at the final index.
- load_valid asserted outside IDLE is ignored; load_data is not sampled.
- Reset mid-word: the word is dropped, no ser_last is issued, and the first cycle after reset release is IDLE with load_ready=1.

Optional Feature:
Macro: MUX_SEQ_PARITY_EN.
- Defined: a ninth beat follows bit 7, carrying even parity (XOR of all mux_in bits).
  - ser_last moves from the bit-7 beat to the parity beat.
  - During the parity beat ser_data comes from an internal parity register, not from mux_out, and mux_sel holds the final index.
  - The counter widens to 4 bits.
- Not defined: exactly 8 beats, no parity logic present.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release → load_ready=1, busy=0, ser_valid=0, mux_sel=0, mux_in=8'h00.
- LSB-first word: load 8'hA5 with ser_ready=1 → ser_data 1,0,1,0,0,1,0,1 on consecutive cycles; mux_sel 0..7; ser_last only on beat 8; load_ready back high the next cycle.
- MSB-first with backpressure: MSB_FIRST=1, load 8'h3C, ser_ready low on beats 3 and 6 for 2 cycles each → sequence 0,0,1,1,1,1,0,0 unchanged; mux_sel, ser_data and ser_last stable during stalls; total 12 cycles in SHIFT.
- Back-to-back with gap: IDLE_GAP=3, two words 8'hFF then 8'h00 with load_valid held high → second word accepted exactly 4 cycles after the first word's last transfer; load_valid ignored while busy=1.
- Reset mid-word: assert rst_n=0 after beat 4 of 8'h96 → next cycle ser_valid=0 and ser_last never seen. After release, a new word 8'h01 serialises correctly from mux_sel=0.
- Parity (MUX_SEQ_PARITY_EN defined): load 8'h07 → 9 beats 1,1,1,0,0,0,0,0,1; ser_last on beat 9 only.
